// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus: instruction memory port, downstream valid/ready
// handshake, redirect request, enable and halt status.
interface instr_fetch_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                en;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                inst_valid;
  logic [31:0]         inst_data;
  logic [PC_WIDTH-1:0] inst_pc;
  logic                inst_ready;
  logic                halted;

  modport master (
    input  en, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_addr, inst_valid, inst_data, inst_pc, halted
  );

  modport slave (
    output en, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_addr, inst_valid, inst_data, inst_pc, halted
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer with a 2-entry prefetch buffer, redirect flush
// and halt-word stop. Define FETCH_PERF_EN to add fetch/stall counters.
module instr_fetch_ctrl #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  PC_STEP    = 1,
  parameter logic [31:0]         HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_ctrl_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  typedef enum logic {S_RUN, S_HALTED} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] hpc_q, hpc_d, tpc_q, tpc_d;
  logic [31:0]         hdat_q, hdat_d, tdat_q, tdat_d;
  logic                pop, fire;

  assign pop  = (cnt_q != 2'd0) & bus.inst_ready;
  assign fire = (state_q == S_RUN) & bus.en & ~bus.redirect_valid &
                ((cnt_q != 2'd2) | pop);

  // Head entry drives the outputs directly; it is left untouched when the
  // buffer empties so inst_data/inst_pc hold their last values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    hpc_d   = hpc_q;
    hdat_d  = hdat_q;
    tpc_d   = tpc_q;
    tdat_d  = tdat_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      cnt_d   = 2'd0;
      state_d = S_RUN;
    end else begin
      if (fire) begin
        pc_d = pc_q + PC_WIDTH'(PC_STEP);
        if (bus.imem_rdata == HALT_INSTR) state_d = S_HALTED;
      end
      case ({pop, fire})
        2'b10: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd2) begin
            hpc_d  = tpc_q;
            hdat_d = tdat_q;
          end
        end
        2'b01: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            hpc_d  = pc_q;
            hdat_d = bus.imem_rdata;
          end else begin
            tpc_d  = pc_q;
            tdat_d = bus.imem_rdata;
          end
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            hpc_d  = pc_q;
            hdat_d = bus.imem_rdata;
          end else begin
            hpc_d  = tpc_q;
            hdat_d = tdat_q;
            tpc_d  = pc_q;
            tdat_d = bus.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
      pc_q    <= RESET_PC;
      hpc_q   <= '0;
      hdat_q  <= '0;
      tpc_q   <= '0;
      tdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      hpc_q   <= hpc_d;
      hdat_q  <= hdat_d;
      tpc_q   <= tpc_d;
      tdat_q  <= tdat_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (cnt_q != 2'd0);
  assign bus.inst_data  = hdat_q;
  assign bus.inst_pc    = hpc_q;
  assign bus.halted     = (state_q == S_HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;
  logic        stall;

  assign stall = (state_q == S_RUN) & bus.en & ~bus.redirect_valid &
                 (cnt_q == 2'd2) & ~pop;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, fire};
    perf_stall_d = perf_stall_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic en, redirect_valid, inst_ready;
  logic [31:0] redirect_pc;
  logic        halt_en;
  logic [31:0] halt_addr;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.PC_WIDTH(32)) bif ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return HALT;
    return a + 32'h100;
  endfunction

  assign bif.en             = en;
  assign bif.redirect_valid = redirect_valid;
  assign bif.redirect_pc    = redirect_pc;
  assign bif.inst_ready     = inst_ready;
  assign bif.imem_rdata     = mem_word(bif.imem_addr);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  instr_fetch_ctrl #(.PC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, word}, a next-fetch PC and a halt flag.
  typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_hpc, m_hdat;
  logic        m_halt;
  int          m_fetches, m_stalls;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc = 32'h0; m_hpc = 32'h0; m_hdat = 32'h0; m_halt = 1'b0;
      m_fetches = 0; m_stalls = 0;
    end else begin
      bit p, f;
      logic [31:0] w;
      p = (mq.size() > 0) && inst_ready;
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc;
        m_halt = 1'b0;
      end else begin
        f = !m_halt && en && (mq.size() < 2 || p);
        if (!m_halt && en && mq.size() == 2 && !p) m_stalls++;
        if (p) void'(mq.pop_front());
        if (f) begin
          w = mem_word(m_pc);
          mq.push_back('{pc: m_pc, d: w});
          if (w == HALT) m_halt = 1'b1;
          m_pc = m_pc + 32'd1;
          m_fetches++;
        end
      end
      if (mq.size() > 0) begin
        m_hpc  = mq[0].pc;
        m_hdat = mq[0].d;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("inst_valid", {31'd0, bif.inst_valid}, {31'd0, mq.size() != 0});
      check("inst_data",  bif.inst_data, m_hdat);
      check("inst_pc",    bif.inst_pc, m_hpc);
      check("imem_addr",  bif.imem_addr, m_pc);
      check("halted",     {31'd0, bif.halted}, {31'd0, m_halt});
`ifdef FETCH_PERF_EN
      check("perf_fetch", perf_fetch_cnt, m_fetches);
      check("perf_stall", perf_stall_cnt, m_stalls);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
`ifdef FETCH_PERF_EN
    logic [31:0] stall0;
`endif
    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; halt_en = 1'b0; halt_addr = '0;
    #1;
    check("rst_valid",  {31'd0, bif.inst_valid}, 32'd0);
    check("rst_data",   bif.inst_data, 32'd0);
    check("rst_pc",     bif.inst_pc, 32'd0);
    check("rst_halted", {31'd0, bif.halted}, 32'd0);
    check("rst_addr",   bif.imem_addr, 32'd0);
    step(2);
    rst_n = 1'b1;

    // streaming, one instruction per cycle
    en = 1'b1; inst_ready = 1'b1;
    step(1);
    check("stream_pc0",   bif.inst_pc, 32'd0);
    check("stream_data0", bif.inst_data, 32'h100);
    step(5);
    check("stream_pc5",   bif.inst_pc, 32'd5);
    check("stream_data5", bif.inst_data, 32'h105);
    check("stream_addr",  bif.imem_addr, 32'd6);

    // backpressure
`ifdef FETCH_PERF_EN
    stall0 = perf_stall_cnt;
`endif
    inst_ready = 1'b0;
    step(5);
    check("bp_pc",   bif.inst_pc, 32'd5);
    check("bp_data", bif.inst_data, 32'h105);
    check("bp_addr", bif.imem_addr, 32'd7);
`ifdef FETCH_PERF_EN
    check("bp_stalls", perf_stall_cnt - stall0, 32'd4);
`endif
    inst_ready = 1'b1;
    step(1);
    check("bp_rel_pc6", bif.inst_pc, 32'd6);
    step(1);
    check("bp_rel_pc7", bif.inst_pc, 32'd7);

    // redirect with two entries buffered and the head popped
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    check("rd_valid", {31'd0, bif.inst_valid}, 32'd0);
    check("rd_addr",  bif.imem_addr, 32'h40);
    redirect_valid = 1'b0;
    step(1);
    check("rd_pc",   bif.inst_pc, 32'h40);
    check("rd_data", bif.inst_data, 32'h140);

    // halt word at address 3
    halt_en = 1'b1; halt_addr = 32'd3;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    step(4);
    check("halt_pc",     bif.inst_pc, 32'd3);
    check("halt_data",   bif.inst_data, HALT);
    check("halt_flag",   {31'd0, bif.halted}, 32'd1);
    check("halt_addr",   bif.imem_addr, 32'd4);
    step(3);
    check("halt_addr2",  bif.imem_addr, 32'd4);
    check("halt_empty",  {31'd0, bif.inst_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step(1);
    check("unhalt_flag", {31'd0, bif.halted}, 32'd0);
    check("unhalt_addr", bif.imem_addr, 32'h10);
    redirect_valid = 1'b0; halt_en = 1'b0;
    step(1);
    check("unhalt_pc",   bif.inst_pc, 32'h10);

    // enable low: pc holds, buffer drains
    en = 1'b0;
    step(3);
    check("en0_addr",  bif.imem_addr, 32'h11);
    check("en0_valid", {31'd0, bif.inst_valid}, 32'd0);
    en = 1'b1;

    // pc wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    check("wrap_pc_fffe", bif.inst_pc, 32'hFFFF_FFFE);
    step(1);
    check("wrap_pc_ffff", bif.inst_pc, 32'hFFFF_FFFF);
    step(1);
    check("wrap_pc_0",    bif.inst_pc, 32'd0);
    check("wrap_data_0",  bif.inst_data, 32'h100);
    step(1);
    check("wrap_pc_1",    bif.inst_pc, 32'd1);

    // asynchronous reset between edges
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bif.inst_valid}, 32'd0);
    check("arst_addr",  bif.imem_addr, 32'd0);
    check("arst_halt",  {31'd0, bif.halted}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    check("arst_restart_pc",    bif.inst_pc, 32'd0);
    check("arst_restart_valid", {31'd0, bif.inst_valid}, 32'd1);
    step(3);
    check("arst_stream_pc", bif.inst_pc, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the word-addressed, combinational-read instruction memory.
- Holds the PC, drives the memory address, captures each returned word with its PC into a 2-entry prefetch buffer, and delivers instructions downstream over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer.
- Stops fetching at a programmable halt word.

Parameters:
- PC_WIDTH, 32, width of the PC and the memory address.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- PC_STEP, 1, PC increment per fetch; the memory holds one instruction per address.
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that halts fetching.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  fetch enable.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  PC_WIDTH  redirect target.
- imem_addr  out  PC_WIDTH  instruction memory address.
- imem_rdata  in  32  instruction memory read data; combinational from imem_addr.
- inst_valid  out  1  buffer head valid.
- inst_data  out  32  head instruction.
- inst_pc  out  PC_WIDTH  head PC.
- inst_ready  in  1  consumer accepts the head.
- halted  out  1  FSM is in HALTED.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - pc=RESET_PC, buffer count=0, FSM=RUN.
  - inst_valid=0, inst_data=0, inst_pc=0, halted=0.
  - imem_addr=RESET_PC.
- imem_addr is driven directly from the pc register. No combinational path from any input to imem_addr.
- Pop: pop = inst_valid & inst_ready.
- Fetch fire: fire = (FSM==RUN) & en & ~redirect_valid & (count<2 | pop).
  - On fire: push {pc, imem_rdata}; pc <= pc + PC_STEP, modulo 2^PC_WIDTH. pc=32'hFFFF_FFFF wraps to 0.
- Latency: the word at pc appears on inst_valid/inst_data the cycle after fire.
- Throughput: 1 instruction/cycle while inst_ready stays high.
- Buffer:
  - 2-entry FIFO; inst_valid = (count!=0); head drives inst_data/inst_pc.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full (count==2) without pop: no fetch, pc holds.
  - Empty: inst_valid=0; inst_data/inst_pc hold their last values.
- Redirect (redirect_valid=1):
  - pc <= redirect_pc; count <= 0; no push that cycle.
  - If pop is also asserted, that head transfer counts as delivered and all remaining entries are discarded.
  - FSM <= RUN, so a redirect exits HALTED.
  - Redirect has priority over fetch, halt and en.
- FSM:
  - RUN -> HALTED when fire and imem_rdata==HALT_INSTR. The halt word itself is pushed and delivered; pc still advances.
  - HALTED: no fetches; buffered entries continue to drain; halted=1.
  - HALTED -> RUN only on redirect_valid or reset.
- en=0: no fetch, pc holds, draining continues.
- Reset mid-operation: all buffered entries are lost immediately; inst_valid drops asynchronously.
- Handshake rule: while inst_valid=1 and inst_ready=0, inst_data/inst_pc are stable until pop or redirect.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt [31:0] and perf_stall_cnt [31:0].
  - perf_fetch_cnt increments on each fire.
  - perf_stall_cnt increments each cycle with FSM==RUN, en=1, redirect_valid=0, count==2 and no pop.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Streaming: reset, en=1, inst_ready=1, memory[i]=i+0x100 -> from cycle 2 after reset release, inst_pc=0,1,2,… and inst_data=0x100,0x101,… on consecutive cycles, with no bubbles.
- Backpressure: stream, then inst_ready=0 for 5 cycles -> count saturates at 2; imem_addr freezes at head_pc+2; inst_data stable. Release ready -> order preserved, no drop or duplication. With FETCH_PERF_EN, perf_stall_cnt increases by 4.
- Redirect: with 2 entries buffered, assert redirect_valid and inst_ready for 1 cycle with redirect_pc=0x40 -> head delivered, second entry discarded; next cycle imem_addr=0x40, inst_valid=0; the following cycle inst_pc=0x40.
- Halt: memory[3]=HALT_INSTR -> PCs 0..3 delivered, halted=1, imem_addr stays 4. Redirect to 0x10 -> halted=0 and fetch resumes at 0x10.
- Wrap: redirect_pc=32'hFFFF_FFFE -> delivered PCs are FFFF_FFFE, FFFF_FFFF, 0, 1.
- Async reset mid-stream: pulse rst_n low between edges -> inst_valid=0 and imem_addr=RESET_PC immediately. After release, fetch restarts at RESET_PC.
